// File: rtl/serial_word_feeder_if.sv
// Word-in / bit-out handshake bundle for the serial word feeder.
// The slave side is the feeder. The master side is its environment: it
// supplies words and consumes bits.
interface serial_word_feeder_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] word_in;
  logic             word_valid;
  logic             word_ready;
  logic             bit_out;
  logic             bit_valid;
  logic             bit_ready;

  modport master (
    output word_in,
    output word_valid,
    output bit_ready,
    input  word_ready,
    input  bit_out,
    input  bit_valid
  );

  modport slave (
    input  word_in,
    input  word_valid,
    input  bit_ready,
    output word_ready,
    output bit_out,
    output bit_valid
  );
endinterface

// File: rtl/serial_word_feeder.sv
// Parallel-in, serial-out feeder: accepts a WIDTH-bit word on a valid/ready
// handshake and streams it one bit per accepted clock, with bubble-free reload.
module serial_word_feeder #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b0,
  parameter int CNTW      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  serial_word_feeder_if.slave      bus,
  output logic                     busy,
  output logic                     word_done,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic [CNTW-1:0]          words_sent
);

  localparam int            IW       = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  if (WIDTH < 2) begin : g_width_check
    $error("serial_word_feeder: WIDTH must be 2 or more");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e            state_q,      state_d;
  logic [WIDTH-1:0]  shreg_q,      shreg_d;
  logic [IW-1:0]     cnt_q,        cnt_d;
  logic              word_done_q,  word_done_d;
  logic [CNTW-1:0]   words_sent_q, words_sent_d;

  logic              last_bit;
  logic              out_bit;
  logic [WIDTH-1:0]  shreg_shifted;

  // The output end is bit 0 for LSB-first and bit WIDTH-1 for MSB-first.
  // Each shift moves the next bit into that position and zero-fills behind it.
  assign out_bit       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg_q[WIDTH-1:1]};
  assign last_bit      = (cnt_q == LAST_IDX);

  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can leave one unassigned and infer a latch.
    state_d        = state_q;
    shreg_d        = shreg_q;
    cnt_d          = cnt_q;
    word_done_d    = 1'b0;
    words_sent_d   = words_sent_q;
    bus.word_ready = 1'b0;
    bus.bit_valid  = 1'b0;
    bus.bit_out    = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.word_ready = 1'b1;
        if (bus.word_valid) begin
          shreg_d = bus.word_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        bus.bit_valid = 1'b1;
        bus.bit_out   = out_bit;
        if (bus.bit_ready) begin
          if (!last_bit) begin
            shreg_d = shreg_shifted;
            cnt_d   = cnt_q + IW'(1);
          end else begin
            // The last bit is leaving, so a new word can load on this same edge.
            word_done_d    = 1'b1;
            words_sent_d   = words_sent_q + CNTW'(1);
            bus.word_ready = 1'b1;
            if (bus.word_valid) begin
              shreg_d = bus.word_in;
              cnt_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      word_done_q  <= 1'b0;
      words_sent_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register sample the old state together at the edge.
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      word_done_q  <= word_done_d;
      words_sent_q <= words_sent_d;
    end
  end

  assign busy       = (state_q == SHIFT);
  assign bit_idx    = (state_q == SHIFT) ? cnt_q : '0;
  assign word_done  = word_done_q;
  assign words_sent = words_sent_q;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed bench for serial_word_feeder: LSB-first, MSB-first and a 2-bit
// counter variant. Covers reset, stall, back-to-back reload, wrap and abort.
module tb_serial_word_feeder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [15:0] word_a = 16'b1011001011010001;
  logic [15:0] word_b = 16'h5A3C;
  int          exp_sent_a = 0;

  serial_word_feeder_if #(.WIDTH(16)) ifa ();
  serial_word_feeder_if #(.WIDTH(16)) ifb ();
  serial_word_feeder_if #(.WIDTH(16)) ifc ();

  logic       busy_a, done_a, busy_b, done_b, busy_c, done_c;
  logic [3:0] idx_a, idx_b, idx_c;
  logic [7:0] sent_a, sent_b;
  logic [1:0] sent_c;

  serial_word_feeder #(.WIDTH(16), .MSB_FIRST(1'b0), .CNTW(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa),
    .busy(busy_a), .word_done(done_a), .bit_idx(idx_a), .words_sent(sent_a)
  );

  serial_word_feeder #(.WIDTH(16), .MSB_FIRST(1'b1), .CNTW(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb),
    .busy(busy_b), .word_done(done_b), .bit_idx(idx_b), .words_sent(sent_b)
  );

  serial_word_feeder #(.WIDTH(16), .MSB_FIRST(1'b0), .CNTW(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ifc),
    .busy(busy_c), .word_done(done_c), .bit_idx(idx_c), .words_sent(sent_c)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++;
    if ({ifa.bit_valid, ifa.bit_out, busy_a, idx_a, done_a, sent_a} !== 16'd0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%b out=%b busy=%b idx=%0d done=%b sent=%0d want all 0",
               ifa.bit_valid, ifa.bit_out, busy_a, idx_a, done_a, sent_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (ifa.word_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b want 1", ifa.word_ready);
    end
  endtask

  task automatic test_basic();
    logic [15:0] w;
    w = word_a;
    @(negedge clk);
    ifa.bit_ready = 1'b1; ifa.word_in = w; ifa.word_valid = 1'b1;
    #1;
    tests++;
    if (ifa.word_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic_idle_ready: got %b want 1", ifa.word_ready);
    end
    @(negedge clk);
    ifa.word_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tests++;
      if ({ifa.bit_valid, busy_a, ifa.bit_out, idx_a, done_a} !== {1'b1, 1'b1, w[i], 4'(i), 1'b0}) begin
        fails++;
        $display("FAIL basic_bit%0d: got valid=%b busy=%b out=%b idx=%0d done=%b want 1/1/%b/%0d/0",
                 i, ifa.bit_valid, busy_a, ifa.bit_out, idx_a, done_a, w[i], i);
      end
      @(negedge clk);
    end
    exp_sent_a++;
    tests++;
    if ({done_a, ifa.bit_valid, busy_a, sent_a} !== {1'b1, 1'b0, 1'b0, 8'(exp_sent_a)}) begin
      fails++;
      $display("FAIL basic_done: got done=%b valid=%b busy=%b sent=%0d want 1/0/0/%0d",
               done_a, ifa.bit_valid, busy_a, sent_a, exp_sent_a);
    end
    @(negedge clk);
    tests++;
    if (done_a !== 1'b0) begin
      fails++;
      $display("FAIL basic_done_pulse: got %b want 0", done_a);
    end
  endtask

  task automatic test_msb_first();
    logic [15:0] w;
    w = word_a;
    @(negedge clk);
    ifb.bit_ready = 1'b1; ifb.word_in = w; ifb.word_valid = 1'b1;
    #1;
    tests++;
    if (ifb.word_ready !== 1'b1) begin
      fails++;
      $display("FAIL msb_idle_ready: got %b want 1", ifb.word_ready);
    end
    @(negedge clk);
    ifb.word_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tests++;
      if ({ifb.bit_valid, busy_b, ifb.bit_out, idx_b, done_b} !== {1'b1, 1'b1, w[15-i], 4'(i), 1'b0}) begin
        fails++;
        $display("FAIL msb_bit%0d: got valid=%b busy=%b out=%b idx=%0d done=%b want 1/1/%b/%0d/0",
                 i, ifb.bit_valid, busy_b, ifb.bit_out, idx_b, done_b, w[15-i], i);
      end
      @(negedge clk);
    end
    tests++;
    if ({done_b, sent_b} !== {1'b1, 8'd1}) begin
      fails++;
      $display("FAIL msb_done: got done=%b sent=%0d want 1/1", done_b, sent_b);
    end
  endtask

  task automatic test_stall();
    logic [15:0] w;
    int exp_idx, stalls, cycles;
    w = word_a; exp_idx = 0; stalls = 0; cycles = 0;
    @(negedge clk);
    ifa.bit_ready = 1'b1; ifa.word_in = w; ifa.word_valid = 1'b1;
    @(negedge clk);
    ifa.word_valid = 1'b0;
    while (cycles < 40 && done_a !== 1'b1) begin
      tests++;
      if ({ifa.bit_valid, ifa.bit_out, idx_a} !== {1'b1, w[exp_idx], 4'(exp_idx)}) begin
        fails++;
        $display("FAIL stall_bit c=%0d: got valid=%b out=%b idx=%0d want 1/%b/%0d",
                 cycles, ifa.bit_valid, ifa.bit_out, idx_a, w[exp_idx], exp_idx);
      end
      if (exp_idx == 5 && stalls < 3) begin
        ifa.bit_ready = 1'b0;
        stalls++;
      end else begin
        ifa.bit_ready = 1'b1;
        exp_idx++;
      end
      @(negedge clk);
      cycles++;
    end
    ifa.bit_ready = 1'b1;
    exp_sent_a++;
    tests++;
    if (done_a !== 1'b1 || cycles != 19 || sent_a !== 8'(exp_sent_a)) begin
      fails++;
      $display("FAIL stall_done: got done=%b cycles=%0d sent=%0d want 1/19/%0d",
               done_a, cycles, sent_a, exp_sent_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w1, w2;
    logic        exp_bit;
    w1 = word_a; w2 = word_b;
    @(negedge clk);
    ifa.bit_ready = 1'b1; ifa.word_in = w1; ifa.word_valid = 1'b1;
    @(negedge clk);
    ifa.word_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      // Second word is offered early with a junk value first; only the
      // value present on the reload edge may be taken.
      if (i >= 10 && i <= 15) begin
        ifa.word_valid = 1'b1;
        ifa.word_in    = (i < 13) ? 16'hFFFF : w2;
        #1;
        tests++;
        if (ifa.word_ready !== (i == 15)) begin
          fails++;
          $display("FAIL b2b_ready i=%0d: got %b want %b", i, ifa.word_ready, (i == 15));
        end
      end else begin
        ifa.word_valid = 1'b0;
      end
      exp_bit = (i < 16) ? w1[i] : w2[i-16];
      tests++;
      if ({ifa.bit_valid, ifa.bit_out, idx_a, done_a} !== {1'b1, exp_bit, 4'(i % 16), (i == 16)}) begin
        fails++;
        $display("FAIL b2b_bit i=%0d: got valid=%b out=%b idx=%0d done=%b want 1/%b/%0d/%b",
                 i, ifa.bit_valid, ifa.bit_out, idx_a, done_a, exp_bit, i % 16, (i == 16));
      end
      @(negedge clk);
    end
    exp_sent_a += 2;
    tests++;
    if ({done_a, ifa.bit_valid, sent_a} !== {1'b1, 1'b0, 8'(exp_sent_a)}) begin
      fails++;
      $display("FAIL b2b_done: got done=%b valid=%b sent=%0d want 1/0/%0d",
               done_a, ifa.bit_valid, sent_a, exp_sent_a);
    end
  endtask

  task automatic send_word_c(input logic [15:0] w, output bit ok);
    @(negedge clk);
    ifc.bit_ready = 1'b1; ifc.word_in = w; ifc.word_valid = 1'b1;
    @(negedge clk);
    ifc.word_valid = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 24; n++) begin
      if (done_c === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap_abort();
    logic [1:0]  exp_c;
    logic [15:0] w;
    bit          ok, seen_done;
    exp_c = 2'd0;
    for (int k = 0; k < 5; k++) begin
      send_word_c(16'h0101 * 16'(k + 1), ok);
      exp_c = exp_c + 2'd1;
      tests++;
      if (!ok || sent_c !== exp_c) begin
        fails++;
        $display("FAIL wrap_word%0d: got done_seen=%b sent=%0d want 1/%0d", k, ok, sent_c, exp_c);
      end
    end

    @(negedge clk);
    ifc.word_in = 16'h1234; ifc.word_valid = 1'b1;
    @(negedge clk);
    ifc.word_valid = 1'b0;
    for (int n = 0; n < 20 && idx_c !== 4'd7; n++) @(negedge clk);
    tests++;
    if ({busy_c, idx_c} !== {1'b1, 4'd7}) begin
      fails++;
      $display("FAIL abort_reach: got busy=%b idx=%0d want 1/7", busy_c, idx_c);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({ifc.bit_valid, busy_c, idx_c, done_c, sent_c, sent_a, sent_b} !== 25'd0) begin
      fails++;
      $display("FAIL abort_async: got valid=%b busy=%b idx=%0d done=%b sent_c=%0d sent_a=%0d sent_b=%0d want all 0",
               ifc.bit_valid, busy_c, idx_c, done_c, sent_c, sent_a, sent_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (ifc.word_ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_ready: got %b want 1", ifc.word_ready);
    end
    seen_done = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done_c === 1'b1 || ifc.bit_valid === 1'b1) seen_done = 1'b1;
    end
    tests++;
    if (seen_done) begin
      fails++;
      $display("FAIL abort_no_done: got activity after abort want none");
    end

    w = 16'h00F1;
    @(negedge clk);
    ifc.word_in = w; ifc.word_valid = 1'b1;
    @(negedge clk);
    ifc.word_valid = 1'b0;
    tests++;
    if ({ifc.bit_valid, ifc.bit_out, idx_c} !== {1'b1, w[0], 4'd0}) begin
      fails++;
      $display("FAIL abort_restart: got valid=%b out=%b idx=%0d want 1/%b/0",
               ifc.bit_valid, ifc.bit_out, idx_c, w[0]);
    end
    ok = 1'b0;
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      if (done_c === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok || sent_c !== 2'd1) begin
      fails++;
      $display("FAIL abort_next_done: got done_seen=%b sent=%0d want 1/1", ok, sent_c);
    end
  endtask

  initial begin
    ifa.word_in = '0; ifa.word_valid = 1'b0; ifa.bit_ready = 1'b1;
    ifb.word_in = '0; ifb.word_valid = 1'b0; ifb.bit_ready = 1'b1;
    ifc.word_in = '0; ifc.word_valid = 1'b0; ifc.bit_ready = 1'b1;
    test_reset();
    test_basic();
    test_msb_first();
    test_stall();
    test_back_to_back();
    test_wrap_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
